// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// reg_arb_pkg : shared types and default sizes for the register write arbiter
// Revision    : 1.0
// ============================================================================
package reg_arb_pkg;

   localparam int DEFAULT_WIDTH = 5;
   localparam int DEFAULT_N     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      WAIT  = 2'd2
   } state_e;

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, searching upward from last+1
// Revision   : 1.0
// ============================================================================
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic          valid_o,
   output logic [IW-1:0] winner_o
);

   int idx;

   always_comb begin
      valid_o  = 1'b0;
      winner_o = '0;
      idx      = 0;
      for (int off = 1; off <= N; off++) begin
         idx = (int'(last_i) + off) % N;
         if (!valid_o && req_i[idx]) begin
            valid_o  = 1'b1;
            winner_o = IW'(idx);
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// reg_write_arbiter : round-robin arbiter granting N requesters one write each
//                     to a shared external register (IDLE -> WRITE -> WAIT)
// Revision          : 1.0
// ============================================================================
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N-1:0]          req_go,
   input  logic [N*WIDTH-1:0]    req_in,
   output logic [N-1:0]          req_done,
   output logic [WIDTH-1:0]      reg_in,
   output logic                  reg_write_en,
   input  logic                  reg_done,
   output logic [$clog2(N)-1:0]  grant_id,
   output logic                  busy,
   output logic                  protocol_err
);

   localparam int IW = $clog2(N);

   state_e           state_q;
   logic [IW-1:0]    grant_q;
   logic [IW-1:0]    last_winner_q;
   logic [WIDTH-1:0] reg_in_q;
   logic             wen_q;
   logic             err_q;

   logic             grant_valid_d;
   logic [IW-1:0]    grant_d;

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_rr_arbiter (
      .req_i    (req_go),
      .last_i   (last_winner_q),
      .valid_o  (grant_valid_d),
      .winner_o (grant_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         last_winner_q <= IW'(N - 1);
         reg_in_q      <= '0;
         wen_q         <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         // A done outside WAIT is flagged but never steers the FSM.
         if (reg_done && (state_q != WAIT)) begin
            err_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (grant_valid_d) begin
                  state_q  <= WRITE;
                  grant_q  <= grant_d;
                  reg_in_q <= req_in[int'(grant_d)*WIDTH +: WIDTH];
                  wen_q    <= 1'b1;
               end
            end
            WRITE: begin
               state_q  <= WAIT;
               reg_in_q <= '0;
               wen_q    <= 1'b0;
            end
            WAIT: begin
               if (reg_done) begin
                  state_q       <= IDLE;
                  last_winner_q <= grant_q;
               end
            end
            default: begin
               state_q  <= IDLE;
               reg_in_q <= '0;
               wen_q    <= 1'b0;
            end
         endcase
      end
   end

   // Completion must coincide with the register's done, hence combinational.
   always_comb begin
      req_done = '0;
      if ((state_q == WAIT) && reg_done) begin
         req_done[grant_q] = 1'b1;
      end
   end

   assign reg_in       = reg_in_q;
   assign reg_write_en = wen_q;
   assign grant_id     = grant_q;
   assign busy         = (state_q != IDLE);
   assign protocol_err = err_q;

endmodule : reg_write_arbiter
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_write_arbiter : scoreboard bench with directed vectors
// Revision             : 1.0
// ============================================================================
module tb_reg_write_arbiter;

   localparam int WIDTH = 5;
   localparam int N     = 4;

   typedef struct {
      logic [1:0]       id;
      logic [WIDTH-1:0] data;
   } wr_t;

   logic                 clk;
   logic                 reset;
   logic [N-1:0]         req_go;
   logic [N*WIDTH-1:0]   req_in;
   logic [N-1:0]         req_done;
   logic [WIDTH-1:0]     reg_in;
   logic                 reg_write_en;
   logic                 reg_done;
   logic [1:0]           grant_id;
   logic                 busy;
   logic                 protocol_err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int cyc = 0;
   bit mon_en = 0;
   bit auto_done = 1;
   bit manual_done = 0;

   wr_t          exp_wr[$];
   logic [N-1:0] exp_done[$];
   int           done_times[$];

   reg_write_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_go       (req_go),
      .req_in       (req_in),
      .req_done     (req_done),
      .reg_in       (reg_in),
      .reg_write_en (reg_write_en),
      .reg_done     (reg_done),
      .grant_id     (grant_id),
      .busy         (busy),
      .protocol_err (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model of the shared register: done the cycle after an accepted write.
   initial begin : reg_model
      bit w;
      reg_done = 1'b0;
      forever begin
         @(negedge clk);
         w = (reg_write_en === 1'b1);
         @(posedge clk);
         #2;
         reg_done = (auto_done && w) || manual_done;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a write or done.
   initial begin : monitor
      wr_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (reg_write_en === 1'b1) begin
               if (exp_wr.size() == 0) begin
                  chk("unexpected_write", {30'd0, grant_id}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_wr.pop_front();
                  chk("write_grant_id", {30'd0, grant_id}, {30'd0, e.id});
                  chk("write_reg_in", {27'd0, reg_in}, {27'd0, e.data});
               end
            end else begin
               chk("reg_in_idle_zero", {27'd0, reg_in}, 32'd0);
            end
            if (req_done !== '0) begin
               done_cnt++;
               done_times.push_back(cyc);
               if (exp_done.size() == 0) begin
                  chk("unexpected_done", {28'd0, req_done}, 32'd0);
               end else begin
                  chk("req_done_vector", {28'd0, req_done}, {28'd0, exp_done.pop_front()});
               end
            end
         end
      end
   end

   task automatic wait_dones(input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt < target) begin
         checks++;
         errors++;
         $display("FAIL timeout_done actual=%0d required=%0d", done_cnt, target);
      end
      #1;
   endtask

   task automatic push_wr(input logic [1:0] id, input logic [WIDTH-1:0] d);
      wr_t e;
      e.id   = id;
      e.data = d;
      exp_wr.push_back(e);
      exp_done.push_back(N'(1) << id);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin : stim
      reset  = 1'b1;
      req_go = '0;
      req_in = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_write_en", {31'd0, reg_write_en}, 32'd0);
      chk("rst_reg_in", {27'd0, reg_in}, 32'd0);
      chk("rst_req_done", {28'd0, req_done}, 32'd0);
      chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
      mon_en = 1'b1;

      // Single request with latency checks.
      @(posedge clk); #1;
      req_in[0*WIDTH +: WIDTH] = 5'd19;
      push_wr(2'd0, 5'd19);
      req_go = 4'b0001;
      @(negedge clk);
      chk("single_idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("single_t1_write_en", {31'd0, reg_write_en}, 32'd1);
      @(negedge clk);
      chk("single_t2_req_done", {28'd0, req_done}, 32'd1);
      wait_dones(1, 20);
      req_go = '0;

      // Fairness after reset: grant order 0,1,2,3,0 at one write per 3 cycles.
      do_reset();
      req_in = {5'd4, 5'd3, 5'd2, 5'd1};
      push_wr(2'd0, 5'd1);
      push_wr(2'd1, 5'd2);
      push_wr(2'd2, 5'd3);
      push_wr(2'd3, 5'd4);
      push_wr(2'd0, 5'd1);
      req_go = 4'b1111;
      wait_dones(6, 60);
      req_go = '0;
      if (done_times.size() >= 5) begin
         chk("fair_period", done_times[done_times.size()-1] - done_times[done_times.size()-5], 32'd12);
      end else begin
         chk("fair_done_count", done_times.size(), 32'd5);
      end

      // Late data change, winner drops go after grant, short-lived request ignored.
      req_in[2*WIDTH +: WIDTH] = 5'd7;
      push_wr(2'd2, 5'd7);
      req_go = 4'b0100;
      @(posedge clk); #1;
      req_in[2*WIDTH +: WIDTH] = 5'd30;
      req_go = 4'b0010;
      wait_dones(7, 20);
      req_go = '0;
      repeat (4) @(negedge clk);
      chk("dropped_req_idle", {31'd0, busy}, 32'd0);

      // Reset in WRITE aborts the op; requester 0 regains first priority.
      auto_done = 1'b0;
      req_in = {5'd9, 5'd0, 5'd0, 5'd19};
      exp_wr.push_back('{id: 2'd3, data: 5'd9});
      req_go = 4'b1000;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      req_go = 4'b1001;
      @(negedge clk);
      chk("midrst_write_en", {31'd0, reg_write_en}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_grant_id", {30'd0, grant_id}, 32'd0);
      @(posedge clk); #1;
      reset     = 1'b0;
      auto_done = 1'b1;
      push_wr(2'd0, 5'd19);
      wait_dones(8, 20);
      req_go = '0;
      chk("midrst_done_count", done_cnt, 32'd8);

      // Spurious done in IDLE sets a sticky error and leaves the FSM idle.
      @(posedge clk); #1;
      manual_done = 1'b1;
      @(posedge clk); #1;
      manual_done = 1'b0;
      @(negedge clk);
      chk("spur_protocol_err", {31'd0, protocol_err}, 32'd1);
      chk("spur_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("spur_sticky", {31'd0, protocol_err}, 32'd1);

      // Stall in WAIT for 10 cycles, then release.
      auto_done = 1'b0;
      req_in[1*WIDTH +: WIDTH] = 5'd12;
      push_wr(2'd1, 5'd12);
      req_go = 4'b0010;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_busy", {31'd0, busy}, 32'd1);
         chk("stall_no_done", {28'd0, req_done}, 32'd0);
      end
      @(posedge clk); #1;
      manual_done = 1'b1;
      @(negedge clk);
      chk("stall_release_done", {28'd0, req_done}, 32'd2);
      @(posedge clk); #1;
      manual_done = 1'b0;
      req_go      = '0;
      auto_done   = 1'b1;
      @(negedge clk);
      chk("stall_back_idle", {31'd0, busy}, 32'd0);
      chk("stall_err_still_set", {31'd0, protocol_err}, 32'd1);

      do_reset();
      @(negedge clk);
      chk("err_cleared_by_reset", {31'd0, protocol_err}, 32'd0);

      repeat (3) @(negedge clk);
      chk("wr_queue_empty", exp_wr.size(), 32'd0);
      chk("done_queue_empty", exp_done.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reg_write_arbiter
`default_nettype wire
